// File: rtl/mat_fetch_responder_if.sv
// Request/response and BRAM read bundle between a row/column requester and mat_fetch_responder.
// Latency: none (signal bundle only).
// Backpressure: none; the requester watches busy, and requests made while busy are dropped.
// Ports: new_request/row_req/col_req/mat_dim (request), a_*/b_* (two BRAM read ports),
//        matA_row/matB_col/row_in/col_in/val_rows/busy (response).
// Modports: master = requester plus BRAM side, slave = responder.
interface mat_fetch_responder_if #(
  parameter int N      = 32,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 10
);
  logic                         new_request;
  logic [IDX_W-1:0]             row_req;
  logic [IDX_W-1:0]             col_req;
  logic [IDX_W:0]               mat_dim;
  logic [ADDR_W-1:0]            a_addr;
  logic                         a_rd_en;
  logic [ELEM_W-1:0]            a_data;
  logic [ADDR_W-1:0]            b_addr;
  logic                         b_rd_en;
  logic [ELEM_W-1:0]            b_data;
  logic [N-1:0][ELEM_W-1:0]     matA_row;
  logic [N-1:0][ELEM_W-1:0]     matB_col;
  logic [IDX_W-1:0]             row_in;
  logic [IDX_W-1:0]             col_in;
  logic                         val_rows;
  logic                         busy;

  modport master (
    output new_request, row_req, col_req, mat_dim, a_data, b_data,
    input  a_addr, a_rd_en, b_addr, b_rd_en, matA_row, matB_col,
           row_in, col_in, val_rows, busy
  );

  modport slave (
    input  new_request, row_req, col_req, mat_dim, a_data, b_data,
    output a_addr, a_rd_en, b_addr, b_rd_en, matA_row, matB_col,
           row_in, col_in, val_rows, busy
  );
endinterface

// File: rtl/mat_fetch_responder.sv
// Fetches row of A and column of B from two BRAMs and returns them as packed vectors.
// Latency: val_rows fires D+READ_LATENCY+1 cycles after the accept cycle.
// Backpressure: none; new_request is accepted only in IDLE and is silently dropped while busy.
// Ports: clk_in, rst_in (async, active high); bus (slave modport) carries the request,
//        both BRAM read ports and the response vectors.
module mat_fetch_responder #(
  parameter int N            = 32,
  parameter int ELEM_W       = 8,
  parameter int IDX_W        = 5,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mat_fetch_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [IDX_W:0]    N_D = (IDX_W+1)'(N);
  localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);

  state_t                           state, state_nx;
  logic [IDX_W-1:0]                 row_q, col_q, k_cnt;
  logic [IDX_W:0]                   dim_q, dim_eff;
  logic [N-1:0][ELEM_W-1:0]         a_vec, b_vec;
  logic                             accept, issue, last_k, last_back;

  // Return-path tags: bit/entry i holds the read issued i+1 cycles ago, so the
  // top entry lines up with the BRAM data of the same cycle.
  logic [READ_LATENCY-1:0]             tag_vld, tag_last;
  logic [READ_LATENCY-1:0][IDX_W-1:0]  tag_idx;

  // Zero or oversize dimensions fall back to the full N.
  assign dim_eff   = (bus.mat_dim == '0 || bus.mat_dim > N_D) ? N_D : bus.mat_dim;
  assign accept    = (state == IDLE) && bus.new_request;
  assign issue     = (state == ISSUE);
  assign last_k    = ({1'b0, k_cnt} == dim_q - (IDX_W+1)'(1));
  assign last_back = tag_vld[READ_LATENCY-1] && tag_last[READ_LATENCY-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (last_k) state_nx = DRAIN;
      DRAIN:   if (last_back) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      k_cnt <= '0;
      row_q <= '0;
      col_q <= '0;
      dim_q <= '0;
    end else if (accept) begin
      k_cnt <= '0;
      row_q <= bus.row_req;
      col_q <= bus.col_req;
      dim_q <= dim_eff;
    end else if (issue) begin
      k_cnt <= k_cnt + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_vld  <= '0;
      tag_last <= '0;
      tag_idx  <= '0;
    end else begin
      tag_vld[0]  <= issue;
      tag_last[0] <= issue && last_k;
      tag_idx[0]  <= k_cnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
        tag_idx[i]  <= tag_idx[i-1];
      end
    end
  end

  // Vectors are cleared on accept so elements at or beyond D read back as zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_vec <= '0;
      b_vec <= '0;
    end else if (accept) begin
      a_vec <= '0;
      b_vec <= '0;
    end else if (tag_vld[READ_LATENCY-1]) begin
      a_vec[tag_idx[READ_LATENCY-1]] <= bus.a_data;
      b_vec[tag_idx[READ_LATENCY-1]] <= bus.b_data;
    end
  end

  // Addresses are zero outside ISSUE so they sit at 0 in and after reset.
  assign bus.a_rd_en  = issue;
  assign bus.b_rd_en  = issue;
  assign bus.a_addr   = issue ? (ADDR_W'(row_q) * N_A + ADDR_W'(k_cnt)) : '0;
  assign bus.b_addr   = issue ? (ADDR_W'(k_cnt) * N_A + ADDR_W'(col_q)) : '0;
  assign bus.matA_row = a_vec;
  assign bus.matB_col = b_vec;
  assign bus.row_in   = row_q;
  assign bus.col_in   = col_q;
  assign bus.val_rows = (state == DONE);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mat_fetch_responder.sv
// Bench for mat_fetch_responder: three lanes (READ_LATENCY 2, 1, 4) driven in lockstep.
// Each lane has a BRAM model and a cycle-level reference model of request/response timing.
// Lane 0 additionally gets hand-computed literal checks from the stimulus process.
module tb_mat_fetch_responder;
  localparam int N  = 32;
  localparam int EW = 8;
  localparam int IW = 5;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          new_request;
  logic [IW-1:0] row_req, col_req;
  logic [IW:0]   mat_dim;
  logic [EW-1:0] mem_a [N*N];
  logic [EW-1:0] mem_b [N*N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int lane, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s lane%0d: got %h expected %h", nm, lane, act, exp);
    end
  endtask

  // Lane 0 outputs exposed for literal checks.
  logic          l0_val, l0_rd;
  logic [AW-1:0] l0_a_addr, l0_b_addr;
  logic [255:0]  l0_a, l0_b;
  logic [IW-1:0] l0_row, l0_col;

  for (genvar g = 0; g < 3; g++) begin : lanes
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    mat_fetch_responder_if #(.N(N), .ELEM_W(EW), .IDX_W(IW), .ADDR_W(AW)) bus ();

    mat_fetch_responder #(.N(N), .ELEM_W(EW), .IDX_W(IW), .ADDR_W(AW), .READ_LATENCY(LAT)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
    );

    assign bus.new_request = new_request;
    assign bus.row_req     = row_req;
    assign bus.col_req     = col_req;
    assign bus.mat_dim     = mat_dim;

    // BRAM model: data for the address presented in cycle t appears in cycle t+LAT.
    logic [EW-1:0] pa [LAT];
    logic [EW-1:0] pb [LAT];
    always @(posedge clk) begin
      pa[0] <= mem_a[bus.a_addr];
      pb[0] <= mem_b[bus.b_addr];
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
    assign bus.a_data = pa[LAT-1];
    assign bus.b_data = pb[LAT-1];

    if (g == 0) begin : exp0
      assign l0_val    = bus.val_rows;
      assign l0_rd     = bus.a_rd_en;
      assign l0_a_addr = bus.a_addr;
      assign l0_b_addr = bus.b_addr;
      assign l0_a      = bus.matA_row;
      assign l0_b      = bus.matB_col;
      assign l0_row    = bus.row_in;
      assign l0_col    = bus.col_in;
    end

    // Reference model: remembers the last accepted request (cycle, D, indices,
    // expected vectors) and derives every output from the timing rules.
    int            t_acc = -1000;
    int            dd = 1;
    logic          have = 1'b0;
    logic [IW-1:0] er = '0, ec = '0;
    logic [255:0]  ea = '0, eb = '0;

    always @(negedge clk) begin
      int  k, dm;
      logic busy_exp, val_exp, rd_exp;
      if (rst) begin
        chk("rst_val",   g, 256'(bus.val_rows), 256'(0));
        chk("rst_busy",  g, 256'(bus.busy),     256'(0));
        chk("rst_rd",    g, 256'({bus.a_rd_en, bus.b_rd_en}), 256'(0));
        chk("rst_addr",  g, 256'({bus.a_addr, bus.b_addr}),   256'(0));
        chk("rst_idx",   g, 256'({bus.row_in, bus.col_in}),   256'(0));
        chk("rst_vecA",  g, 256'(bus.matA_row), 256'(0));
        chk("rst_vecB",  g, 256'(bus.matB_col), 256'(0));
        have = 1'b0; t_acc = -1000; er = '0; ec = '0; ea = '0; eb = '0;
      end else begin
        busy_exp = have && cyc > t_acc && cyc <= t_acc + dd + LAT + 1;
        val_exp  = have && cyc == t_acc + dd + LAT + 1;
        rd_exp   = have && cyc >= t_acc + 1 && cyc <= t_acc + dd;
        chk("val_rows", g, 256'(bus.val_rows), 256'(val_exp));
        chk("busy",     g, 256'(bus.busy),     256'(busy_exp));
        chk("a_rd_en",  g, 256'(bus.a_rd_en),  256'(rd_exp));
        chk("b_rd_en",  g, 256'(bus.b_rd_en),  256'(rd_exp));
        if (rd_exp) begin
          k = cyc - t_acc - 1;
          chk("a_addr", g, 256'(bus.a_addr), 256'(int'(er) * N + k));
          chk("b_addr", g, 256'(bus.b_addr), 256'(k * N + int'(ec)));
        end
        chk("row_in", g, 256'(bus.row_in), 256'(er));
        chk("col_in", g, 256'(bus.col_in), 256'(ec));
        if (!busy_exp || val_exp) begin
          chk("matA_row", g, 256'(bus.matA_row), ea);
          chk("matB_col", g, 256'(bus.matB_col), eb);
        end
        if (new_request && !busy_exp) begin
          dm = int'(mat_dim);
          dd = (dm == 0 || dm > N) ? N : dm;
          t_acc = cyc; er = row_req; ec = col_req; have = 1'b1;
          ea = '0; eb = '0;
          for (int j = 0; j < dd; j++) begin
            ea[j*8 +: 8] = mem_a[int'(er) * N + j];
            eb[j*8 +: 8] = mem_b[j * N + int'(ec)];
          end
        end
      end
    end
  end

  task automatic drive(input logic nr, input int r, input int c, input int d);
    new_request = nr;
    row_req     = IW'(r);
    col_req     = IW'(c);
    mat_dim     = (IW+1)'(d);
  endtask

  // One-cycle request; returns one #1 into the cycle after the accept cycle.
  task automatic pulse_req(input int r, input int c, input int d);
    @(posedge clk); #1 drive(1'b1, r, c, d);
    @(posedge clk); #1 drive(1'b0, r, c, d);
  endtask

  task automatic wait_l0_val(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (l0_val) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, n_rd, seen;
    logic [255:0] lit;
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mem_a[i*N+j] = EW'(i + j);
        mem_b[i*N+j] = (i == j) ? 8'd1 : 8'd0;
      end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(100);
    chk("idle_rd",  0, 256'(l0_rd),  256'(0));
    chk("idle_val", 0, 256'(l0_val), 256'(0));

    // A[i][j]=i+j, B=identity, D=32 via mat_dim=0.
    pulse_req(3, 5, 0);
    wait_l0_val(lat);
    chk("lat_d32", 0, 256'(lat), 256'(35));
    chk("a_elem0", 0, 256'(l0_a[7:0]), 256'(3));
    chk("a_elem31", 0, 256'(l0_a[255:248]), 256'(34));
    lit = 256'(1) << 40;
    chk("b_onehot5", 0, l0_b, lit);
    chk("row_in3", 0, 256'(l0_row), 256'(3));
    chk("col_in5", 0, 256'(l0_col), 256'(5));
    @(negedge clk);
    chk("val_width", 0, 256'(l0_val), 256'(0));
    idle(50);

    // D=3, row r of A holds r+1.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mem_a[i*N+j] = EW'(i + 1);
    pulse_req(2, 0, 3);
    wait_l0_val(lat);
    chk("lat_d3", 0, 256'(lat), 256'(6));
    chk("a_d3", 0, l0_a, 256'h030303);
    chk("b_d3", 0, l0_b, 256'h1);
    idle(50);

    // Requests every cycle: the model decides which ones are accepted.
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #1 drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 40));
    end
    @(posedge clk); #1 drive(1'b0, 0, 0, 0);
    idle(50);

    // Corner addresses.
    pulse_req(31, 31, 32);
    n_rd = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (l0_rd) begin
        if (n_rd == 0) begin
          chk("a_addr_first", 0, 256'(l0_a_addr), 256'(992));
          chk("b_addr_first", 0, 256'(l0_b_addr), 256'(31));
        end
        if (n_rd == 31) begin
          chk("a_addr_last", 0, 256'(l0_a_addr), 256'(1023));
          chk("b_addr_last", 0, 256'(l0_b_addr), 256'(1023));
        end
        n_rd++;
      end
    end
    chk("rd_count", 0, 256'(n_rd), 256'(32));
    idle(10);

    // Asynchronous reset in the middle of ISSUE.
    pulse_req(7, 9, 32);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd",   0, 256'(l0_rd),  256'(0));
    chk("arst_vecA", 0, l0_a, 256'(0));
    chk("arst_row",  0, 256'(l0_row), 256'(0));
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (l0_val) seen++;
    end
    chk("no_val_after_rst", 0, 256'(seen), 256'(0));

    // Random contents, random requests and gaps.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < N*N; i++) begin
        mem_a[i] = EW'($urandom);
        mem_b[i] = EW'($urandom);
      end
      for (int r = 0; r < 30; r++) begin
        @(posedge clk); #1 drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63));
        @(posedge clk); #1 drive(1'b0, 0, 0, 0);
        repeat ($urandom_range(0, 45)) @(posedge clk);
      end
      idle(50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
